// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, field indices and operand type for the FPU adder datapath
package fpu_pkg;
   localparam int OP_W     = 37;
   localparam int EXP_W    = 8;
   localparam int MANT_W   = 28;
   localparam int SIGN_BIT = 36;
   localparam int EXP_HI   = 35;
   localparam int EXP_LO   = 28;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fpu_op_t;

   // Builds an operand from its three fields.
   function automatic fpu_op_t pack_op(input logic s, input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
      fpu_op_t r;
      r.sign = s;
      r.exp  = e;
      r.mant = m;
      return r;
   endfunction
endpackage

// File: rtl/fpu_align_add_if.sv
// fpu_align_add_if: operand-pair input and unrounded-result output handshakes
interface fpu_align_add_if;
   import fpu_pkg::*;
   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_a;
   logic [OP_W-1:0]   in_b;
   logic              in_sw;
   logic              in_sub;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic              out_sign;
   logic [EXP_W-1:0]  out_exp;
   logic [MANT_W:0]   out_mant;
   logic              out_zero;

   modport master (
      output in_valid, in_a, in_b, in_sw, in_sub, flush, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_mant, out_zero
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sw, in_sub, flush, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_mant, out_zero
   );
endinterface

// File: rtl/fpu_align_add_align_shift.sv
// align_shift: right shifter for mantissa alignment; sticky collection built only with FPU_ALIGN_STICKY_EN
module align_shift #(
   parameter int W   = 28,
   parameter int A_W = 9
) (
   input  logic [W-1:0]   i_mant,
   input  logic [A_W-1:0] i_amt,
   output logic [W-1:0]   o_mant,
   output logic           o_sticky
);
   localparam logic [A_W-1:0] L_W = A_W'(W);

   logic w_big;

   assign w_big  = i_amt >= L_W;
   assign o_mant = w_big ? '0 : i_mant >> i_amt;
`ifdef FPU_ALIGN_STICKY_EN
   // Shifting by W or more loses every bit, so the whole mantissa feeds sticky.
   assign o_sticky = |(w_big ? i_mant : i_mant & ~({W{1'b1}} << i_amt));
`else
   assign o_sticky = 1'b0;
`endif
endmodule

// File: rtl/fpu_align_add.sv
// fpu_align_add: two-stage align + mantissa add/sub; FPU_ALIGN_STICKY_EN enables sticky alignment
module fpu_align_add #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   fpu_align_add_if.slave   bus
);
   logic              w_a_sign, w_b_sign;
   logic [EXP_W-1:0]  w_a_exp, w_b_exp;
   logic [MANT_W-1:0] w_a_mant, w_b_mant, w_b_shr, w_b_al;
   logic [EXP_W:0]    w_d_raw, w_d;
   logic              w_sticky, w_s1_adv, w_s2_adv, w_eff_sub, w_rs, w_zero;
   logic [MANT_W:0]   w_sum;

   logic              r_s1_valid, r_s1_sign, r_s1_sub;
   logic [EXP_W-1:0]  r_s1_exp;
   logic [MANT_W-1:0] r_s1_mant_a, r_s1_mant_b;
   logic              r_s2_valid, r_s2_sign, r_s2_zero;
   logic [EXP_W-1:0]  r_s2_exp;
   logic [MANT_W:0]   r_s2_mant;

   assign {w_a_sign, w_a_exp, w_a_mant} = bus.in_a;
   assign {w_b_sign, w_b_exp, w_b_mant} = bus.in_b;

   // A smaller exponent on A is an upstream ordering violation; treat it as no shift.
   assign w_d_raw   = {1'b0, w_a_exp} - {1'b0, w_b_exp};
   assign w_d       = w_d_raw[EXP_W] ? '0 : w_d_raw;
   assign w_eff_sub = bus.in_sub ^ w_a_sign ^ w_b_sign;
   assign w_rs      = bus.in_sw ? (w_a_sign ^ bus.in_sub) : w_a_sign;

   align_shift #(.W(MANT_W), .A_W(EXP_W + 1)) u_shift (
      .i_mant   (w_b_mant),
      .i_amt    (w_d),
      .o_mant   (w_b_shr),
      .o_sticky (w_sticky)
   );

   assign w_b_al = w_b_shr | {{(MANT_W-1){1'b0}}, w_sticky};

   // A >= B in magnitude, so the subtract never underflows.
   assign w_sum  = r_s1_sub ? {1'b0, r_s1_mant_a} - {1'b0, r_s1_mant_b}
                            : {1'b0, r_s1_mant_a} + {1'b0, r_s1_mant_b};
   assign w_zero = w_sum == '0;

   assign w_s2_adv     = ~r_s2_valid | bus.out_ready;
   assign w_s1_adv     = ~r_s1_valid | w_s2_adv;
   assign bus.in_ready = bus.flush | w_s1_adv;

   // Stage 1: capture the aligned pair on an advance; flush empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_sign   <= 1'b0;
         r_s1_sub    <= 1'b0;
         r_s1_exp    <= '0;
         r_s1_mant_a <= '0;
         r_s1_mant_b <= '0;
      end else begin
         r_s1_valid <= bus.flush ? 1'b0 : (w_s1_adv ? bus.in_valid : r_s1_valid);
         if (w_s1_adv && bus.in_valid && !bus.flush) begin
            r_s1_sign   <= w_rs;
            r_s1_sub    <= w_eff_sub;
            r_s1_exp    <= w_a_exp;
            r_s1_mant_a <= w_a_mant;
            r_s1_mant_b <= w_b_al;
         end
      end
   end

   // Stage 2: capture the raw sum; an exact-zero result is forced positive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_sign  <= 1'b0;
         r_s2_zero  <= 1'b0;
         r_s2_exp   <= '0;
         r_s2_mant  <= '0;
      end else begin
         r_s2_valid <= bus.flush ? 1'b0 : (w_s2_adv ? r_s1_valid : r_s2_valid);
         if (w_s2_adv && r_s1_valid && !bus.flush) begin
            r_s2_sign <= w_zero ? 1'b0 : r_s1_sign;
            r_s2_zero <= w_zero;
            r_s2_exp  <= r_s1_exp;
            r_s2_mant <= w_sum;
         end
      end
   end

   assign bus.out_valid = r_s2_valid;
   assign bus.out_sign  = r_s2_sign;
   assign bus.out_exp   = r_s2_exp;
   assign bus.out_mant  = r_s2_mant;
   assign bus.out_zero  = r_s2_zero;
endmodule

// File: tb/tb_fpu_align_add.sv
// tb_fpu_align_add: directed vectors for fpu_align_add (expectations follow FPU_ALIGN_STICKY_EN)
module tb_fpu_align_add;
   import fpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fpu_align_add_if bus ();

   fpu_align_add dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic put(input fpu_op_t a, input fpu_op_t b, input logic sw, input logic sub);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sw    = sw;
      bus.in_sub   = sub;
      bus.in_valid = 1'b1;
   endtask

   // Presents one pair at a negedge and checks the result two edges later.
   task automatic single(input string tag, input fpu_op_t a, input fpu_op_t b, input logic sw, input logic sub,
                         input logic [28:0] e_mant, input logic [7:0] e_exp, input logic e_sign, input logic e_zero);
      @(negedge clk);
      put(a, b, sw, sub);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({tag, "_lat"}, 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_mant"}, 64'(bus.out_mant), 64'(e_mant));
      check({tag, "_exp"}, 64'(bus.out_exp), 64'(e_exp));
      check({tag, "_sign"}, 64'(bus.out_sign), 64'(e_sign));
      check({tag, "_zero"}, 64'(bus.out_zero), 64'(e_zero));
   endtask

   logic [28:0] stream_exp [5] = '{29'h1000001, 29'h2000002, 29'h3000003, 29'h4000004, 29'h5000005};

`ifdef FPU_ALIGN_STICKY_EN
   localparam logic [28:0] E_STICKY = 29'h8800001;
   localparam logic [28:0] E_HUGE   = 29'h8000001;
   localparam logic [28:0] E_D28    = 29'h8000001;
`else
   localparam logic [28:0] E_STICKY = 29'h8800000;
   localparam logic [28:0] E_HUGE   = 29'h8000000;
   localparam logic [28:0] E_D28    = 29'h8000000;
`endif

   initial begin
      int sent, recv;
      logic fi, fo;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_sw     = 1'b0;
      bus.in_sub    = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_sign", 64'(bus.out_sign), 64'd0);
      check("rst_exp", 64'(bus.out_exp), 64'd0);
      check("rst_mant", 64'(bus.out_mant), 64'd0);
      check("rst_zero", 64'(bus.out_zero), 64'd0);
      check("rst_ready", 64'(bus.in_ready), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      single("eq_add", pack_op(0, 8'h80, 28'h8000000), pack_op(0, 8'h80, 28'h8000000), 0, 0, 29'h10000000, 8'h80, 0, 0);
      single("cancel", pack_op(1, 8'h80, 28'h8000000), pack_op(1, 8'h80, 28'h8000000), 0, 1, 29'h0, 8'h80, 0, 1);
      single("sticky", pack_op(0, 8'h84, 28'h8000000), pack_op(0, 8'h80, 28'h800000F), 0, 0, E_STICKY, 8'h84, 0, 0);
      single("huge", pack_op(0, 8'hA0, 28'h8000000), pack_op(0, 8'h80, 28'h0000001), 0, 0, E_HUGE, 8'hA0, 0, 0);
      single("swsub", pack_op(0, 8'h81, 28'h8000000), pack_op(0, 8'h80, 28'h8000000), 1, 1, 29'h4000000, 8'h81, 1, 0);
      single("d27", pack_op(0, 8'h9B, 28'h8000000), pack_op(0, 8'h80, 28'h8000000), 0, 0, 29'h8000001, 8'h9B, 0, 0);
      single("d28", pack_op(0, 8'h9C, 28'h8000000), pack_op(0, 8'h80, 28'h8000000), 0, 0, E_D28, 8'h9C, 0, 0);
      single("negd", pack_op(0, 8'h80, 28'h1000000), pack_op(0, 8'h81, 28'h2000000), 0, 0, 29'h3000000, 8'h80, 0, 0);
      single("sgnsub", pack_op(1, 8'h82, 28'h8000000), pack_op(0, 8'h80, 28'h8000000), 0, 0, 29'h6000000, 8'h82, 1, 0);

      // Stream five pairs against out_ready pattern 1,0,0,1.
      @(negedge clk);
      sent = 0;
      recv = 0;
      for (int c = 0; c < 60 && recv < 5; c++) begin
         bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
         if (sent < 5)
            put(pack_op(0, 8'h80, 28'(32'h1000000 * (sent + 1))), pack_op(0, 8'h80, 28'(sent + 1)), 0, 0);
         else
            bus.in_valid = 1'b0;
         #1;
         fi = bus.in_valid & bus.in_ready;
         fo = bus.out_valid & bus.out_ready;
         if (fo) begin
            check($sformatf("stream%0d", recv), 64'(bus.out_mant), 64'(stream_exp[recv]));
            recv++;
         end
         @(posedge clk);
         if (fi) sent++;
         @(negedge clk);
      end
      check("stream_count", 64'(recv), 64'd5);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("stream_nodup", 64'(bus.out_valid), 64'd0);

      // Fill both stages under backpressure, then push+pop, then flush.
      bus.out_ready = 1'b0;
      put(pack_op(0, 8'h80, 28'h0100000), pack_op(0, 8'h80, 28'h1), 0, 0);
      @(negedge clk);
      put(pack_op(0, 8'h80, 28'h0200000), pack_op(0, 8'h80, 28'h2), 0, 0);
      @(negedge clk);
      put(pack_op(0, 8'h80, 28'h0300000), pack_op(0, 8'h80, 28'h3), 0, 0);
      #1;
      check("bp_ready", 64'(bus.in_ready), 64'd0);
      check("bp_mant", 64'(bus.out_mant), 64'h0100001);
      @(negedge clk);
      check("bp_hold", 64'(bus.out_mant), 64'h0100001);
      bus.out_ready = 1'b1;
      #1;
      check("pp_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      check("pp_valid", 64'(bus.out_valid), 64'd1);
      check("pp_mant", 64'(bus.out_mant), 64'h0200002);
      bus.out_ready = 1'b0;
      put(pack_op(0, 8'h80, 28'h0400000), pack_op(0, 8'h80, 28'h4), 0, 0);
      #1;
      check("full_ready", 64'(bus.in_ready), 64'd0);
      bus.flush = 1'b1;
      #1;
      check("flush_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_valid", 64'(bus.out_valid), 64'd0);
      check("flush_ready2", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("flush_drop", 64'(bus.out_valid), 64'd0);

      // Asynchronous reset mid-operation discards a held result.
      bus.out_ready = 1'b0;
      put(pack_op(0, 8'h80, 28'h0500000), pack_op(0, 8'h80, 28'h5), 0, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("ar_pre", 64'(bus.out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", 64'(bus.out_valid), 64'd0);
      check("ar_mant", 64'(bus.out_mant), 64'd0);
      check("ar_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fpu_align_add.md
# fpu_align_add

Two-stage pipelined alignment and mantissa add/subtract stage of the FPU adder-subtractor. It sits directly downstream of the compare/normalize stage and consumes its ordered operand pair: A is the larger magnitude, B is the smaller. It right-aligns B to A's exponent with sticky collection, then adds or subtracts the mantissas. It delivers an unrounded sign/exponent/29-bit mantissa result to the rounding/normalize stage over a valid/ready handshake.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MANT_W`, default 28: mantissa field width.
- `clk` input 1: single clock. Everything samples on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input operand pair is valid.
- `in_ready` output 1: stage accepts the pair this cycle. Combinational.
- `in_a` input 37: larger operand. Bit [36] sign, [35:28] exponent, [27:0] mantissa.
- `in_b` input 37: smaller operand, same field layout.
- `in_sw` input 1: operands were swapped upstream, so A is the original second operand.
- `in_sub` input 1: instruction-level subtract (FSUB=1, FADD=0).
- `flush` input 1: synchronous kill of all in-flight entries.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_sign` output 1: result sign.
- `out_exp` output 8: result exponent, equal to A's exponent.
- `out_mant` output 29: raw sum. Bit [28] is the carry.
- `out_zero` output 1: mantissa result is exactly zero.

## Operation
- **Stage 1 (align):**
  - `d = expA - expB`, computed 9-bit.
  - If `d` is negative, clamp `d` to 0. This is a protocol violation.
  - If `d >= MANT_W`, aligned B = 0.
  - Otherwise aligned B = `mantB >> d`.
  - Effective subtract: `eff_sub = in_sub ^ signA ^ signB`.
  - Result sign: `rs = in_sw ? (signA ^ in_sub) : signA`.
  - Register: `rs`, `expA`, `mantA`, aligned B, `eff_sub`.
- **Stage 2 (add):**
  - `eff_sub = 0`: `out_mant = {1'b0,mantA} + {1'b0,alignedB}`.
  - `eff_sub = 1`: `out_mant = {1'b0,mantA} - {1'b0,alignedB}`. This is always non-negative because A ≥ B.
  - Zero result: `out_zero = 1` and `out_sign = 0`.
- **Handshake:**
  - A transfer occurs when valid and ready are both high in the same cycle.
  - `s2_adv = ~s2_valid | out_ready`.
  - `in_ready = ~s1_valid | s2_adv`.
  - Data registers load only on an advance. A stalled stage holds its contents bit-for-bit.
- **Flush:** clears `s1_valid` and `s2_valid` at the next edge and takes priority over any transfer. `in_ready = 1` in the flush cycle. A pair presented in the flush cycle is dropped.
- **Reset:** `out_valid = 0`, `out_sign = 0`, `out_exp = 0`, `out_mant = 0`, `out_zero = 0`. `in_ready = 1` immediately after reset. Asserting `rst_n` mid-operation discards all entries asynchronously.

## Timing
- Latency is 2 cycles: input accepted at edge N, `out_valid` high after edge N+1.
- Throughput is 1 result per cycle with `out_ready` held high.
- Backpressure: with `out_ready` low and both stages full, `in_ready` drops in the same cycle. No entry is lost or duplicated.
- Simultaneous output pop and input push while full: both complete, pipeline stays full.
- `out_*` are driven directly from stage-2 registers, with no combinational path from inputs.

## Configuration
- `FPU_ALIGN_STICKY_EN` defined:
  - Any 1 bit shifted out of B is ORed into bit 0 of aligned B.
  - For `d >= MANT_W`, aligned B = `{27'b0, |mantB}`.
- `FPU_ALIGN_STICKY_EN` undefined: shifted-out bits are discarded (truncation), and `d >= MANT_W` gives 0.

## Structure
- Package `fpu_pkg` holds:
  - `OP_W=37`, `EXP_W`, `MANT_W`.
  - Field indices `SIGN_BIT=36`, `EXP_HI=35`, `EXP_LO=28`.
  - Typedef `fpu_op_t` as a packed struct with sign/exp/mant fields.
- Sub-module `align_shift`: combinational right shifter taking the mantissa and a 9-bit amount, producing the shifted mantissa plus sticky. The sticky logic is gated by the macro.

## Test plan
- Equal add: A = B = {0, 0x80, 0x8000000}, `in_sub=0` → after 2 cycles `out_mant=0x10000000`, `out_exp=0x80`, `out_sign=0`.
- Exact cancel: same operands with `in_sub=1` → `out_mant=0`, `out_zero=1`, `out_sign=0`.
- Sticky alignment: A = {0,0x84,0x8000000}, B = {0,0x80,0x800000F}, add.
  - With the macro → aligned B = 0x0800001, `out_mant=0x8800001`.
  - Without the macro → aligned B = 0x0800000, `out_mant=0x8800000`.
- Huge difference: expA=0xA0, expB=0x80, mantB=0x0000001.
  - With the macro → aligned B = 1.
  - Without the macro → aligned B = 0 and `out_mant=mantA`.
- Swapped subtract sign: A = {0,0x81,0x8000000}, B = {0,0x80,0x8000000}, `in_sw=1`, `in_sub=1` → `out_sign=1`, `out_mant=0x4000000`.
- Backpressure and flush:
  - Stream 5 pairs with `out_ready` toggled 1,0,0,1… → 5 results in order, none duplicated.
  - Assert `flush` with both stages full → `out_valid=0` next cycle, `in_ready=1`.
